// File: rtl/dac_frame_receiver.sv
// Oversampling receiver for the CS/SCLK/data DAC link: synchronizes the pins, assembles
// MSB-first frames and reports command/sample. Optional lane B compare under LANE_CHECK_EN.
module dac_frame_receiver #(
    parameter int unsigned FRAME_BITS  = 16,
    parameter int unsigned SAMPLE_BITS = 12
) (
    input  logic                              inClk,
    input  logic                              inResetN,
    input  logic                              inChipSelect,
    input  logic                              inSerialClk,
    input  logic                              inDataA,
    input  logic                              inDataB,
    output logic [FRAME_BITS-SAMPLE_BITS-1:0] outCommand,
    output logic [SAMPLE_BITS-1:0]            outSample,
    output logic                              outValid,
    output logic                              outFrameError,
    output logic                              outLaneError,
    output logic                              outBusy
);

    localparam int unsigned CntW = $clog2(FRAME_BITS + 2);
    localparam logic [CntW-1:0] CntFull = CntW'(FRAME_BITS);
    localparam logic [CntW-1:0] CntMax  = CntW'(FRAME_BITS + 1);

    typedef enum logic [1:0] {StArm, StIdle, StShift} state_t;

    state_t                  stateQ, stateD;
    logic [1:0]              armCntQ;
    logic [2:0]              csSync, sclkSync;
    logic [1:0]              aSync;
    logic [FRAME_BITS-1:0]   shiftA;
    logic [CntW-1:0]         countQ;

    logic csFall, csRise, sclkRise;
    logic clearShift, shiftEn, frameEnd, accept;

    assign csFall   = ~csSync[1] & csSync[2];
    assign csRise   = csSync[1] & ~csSync[2];
    assign sclkRise = sclkSync[1] & ~sclkSync[2];

    assign clearShift = (stateQ == StIdle) && csFall;
    assign frameEnd   = (stateQ == StShift) && csRise;
    // CS rise takes priority over a coincident SCLK edge.
    assign shiftEn    = (stateQ == StShift) && !csRise && sclkRise;
    assign accept     = frameEnd && (countQ == CntFull);

    always_ff @(posedge inClk or negedge inResetN) begin
        if (!inResetN) begin
            csSync   <= 3'b111;
            sclkSync <= 3'b000;
            aSync    <= 2'b00;
        end else begin
            csSync   <= {csSync[1:0], inChipSelect};
            sclkSync <= {sclkSync[1:0], inSerialClk};
            aSync    <= {aSync[0], inDataA};
        end
    end

    always_ff @(posedge inClk or negedge inResetN) begin
        if (!inResetN) begin
            stateQ  <= StArm;
            armCntQ <= 2'd0;
        end else begin
            stateQ  <= stateD;
            if (stateQ == StArm && armCntQ != 2'd2) armCntQ <= armCntQ + 2'd1;
        end
    end

    // ARM waits until the synchronizers hold real pin values, then for CS high, so a frame
    // already running at reset release is dropped.
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StArm:   if (armCntQ == 2'd2 && csSync[1]) stateD = StIdle;
            StIdle:  if (csFall) stateD = StShift;
            StShift: if (csRise) stateD = StIdle;
            default: stateD = StArm;
        endcase
    end

    always_ff @(posedge inClk or negedge inResetN) begin
        if (!inResetN) begin
            shiftA        <= '0;
            countQ        <= '0;
            outCommand    <= '0;
            outSample     <= '0;
            outValid      <= 1'b0;
            outFrameError <= 1'b0;
            outBusy       <= 1'b0;
        end else begin
            outValid      <= accept;
            outFrameError <= frameEnd && (countQ != CntFull) && (countQ != '0);
            outBusy       <= (stateD == StShift);
            if (clearShift) begin
                shiftA <= '0;
                countQ <= '0;
            end else if (shiftEn) begin
                shiftA <= {shiftA[FRAME_BITS-2:0], aSync[1]};
                if (countQ != CntMax) countQ <= countQ + 1'b1;
            end
            if (accept) begin
                outCommand <= shiftA[FRAME_BITS-1:SAMPLE_BITS];
                outSample  <= shiftA[SAMPLE_BITS-1:0];
            end
        end
    end

`ifdef LANE_CHECK_EN
    logic [1:0]            bSync;
    logic [FRAME_BITS-1:0] shiftB;

    always_ff @(posedge inClk or negedge inResetN) begin
        if (!inResetN) begin
            bSync        <= 2'b00;
            shiftB       <= '0;
            outLaneError <= 1'b0;
        end else begin
            bSync <= {bSync[0], inDataB};
            if (clearShift) shiftB <= '0;
            else if (shiftEn) shiftB <= {shiftB[FRAME_BITS-2:0], bSync[1]};
            if (accept && (shiftA != shiftB)) outLaneError <= 1'b1;
        end
    end
`else
    logic unusedDataB;
    assign unusedDataB  = inDataB;
    assign outLaneError = 1'b0;
`endif

endmodule

// File: tb/tb_dac_frame_receiver.sv
// Directed bench for dac_frame_receiver; serial link driven at SCLK = inClk/8.
module tb_dac_frame_receiver;

    logic        inClk = 1'b0;
    logic        inResetN = 1'b0;
    logic        inChipSelect = 1'b1;
    logic        inSerialClk = 1'b0;
    logic        inDataA = 1'b0;
    logic        inDataB = 1'b0;
    logic [3:0]  outCommand;
    logic [11:0] outSample;
    logic        outValid, outFrameError, outLaneError, outBusy;

    int vectors = 0;
    int miscompares = 0;
    int validCnt = 0;
    int errCnt = 0;
    int bothCnt = 0;
    int v0, e0;

    dac_frame_receiver #(.FRAME_BITS(16), .SAMPLE_BITS(12)) dut (
        .inClk(inClk), .inResetN(inResetN), .inChipSelect(inChipSelect),
        .inSerialClk(inSerialClk), .inDataA(inDataA), .inDataB(inDataB),
        .outCommand(outCommand), .outSample(outSample), .outValid(outValid),
        .outFrameError(outFrameError), .outLaneError(outLaneError), .outBusy(outBusy)
    );

    always #5 inClk = ~inClk;

    always @(posedge inClk) begin
        if (outValid) validCnt <= validCnt + 1;
        if (outFrameError) errCnt <= errCnt + 1;
        if (outValid && outFrameError) bothCnt <= bothCnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge inClk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic csLow();
        inChipSelect = 1'b0;
        cyc(4);
    endtask

    task automatic csHigh();
        inSerialClk = 1'b0;
        cyc(4);
        inChipSelect = 1'b1;
        cyc(8);
    endtask

    // Sends bits [hi:lo] of a/b MSB first.
    task automatic sendBits(input logic [31:0] a, input logic [31:0] b, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            inSerialClk = 1'b0;
            inDataA = a[i];
            inDataB = b[i];
            cyc(4);
            inSerialClk = 1'b1;
            cyc(4);
        end
    endtask

    task automatic frame(input logic [31:0] a, input logic [31:0] b, input int n);
        csLow();
        sendBits(a, b, n - 1, 0);
        csHigh();
    endtask

    task automatic snap();
        v0 = validCnt;
        e0 = errCnt;
    endtask

    initial begin
        cyc(3);
        check("rst_cmd", 32'(outCommand), 32'h0);
        check("rst_sample", 32'(outSample), 32'h0);
        check("rst_valid", 32'(outValid), 32'h0);
        check("rst_ferr", 32'(outFrameError), 32'h0);
        check("rst_lerr", 32'(outLaneError), 32'h0);
        check("rst_busy", 32'(outBusy), 32'h0);
        inResetN = 1'b1;
        cyc(8);

        snap();
        frame(32'h37D0, 32'h37D0, 16);
        check("good_valid", 32'(validCnt - v0), 32'd1);
        check("good_ferr", 32'(errCnt - e0), 32'd0);
        check("good_cmd", 32'(outCommand), 32'h3);
        check("good_sample", 32'(outSample), 32'h7D0);
        check("good_busy_after", 32'(outBusy), 32'h0);

        snap();
        frame(32'h1555, 32'h1555, 15);
        check("short_ferr", 32'(errCnt - e0), 32'd1);
        frame(32'h1ABCD, 32'h1ABCD, 17);
        check("long_ferr", 32'(errCnt - e0), 32'd2);
        check("bad_valid", 32'(validCnt - v0), 32'd0);
        check("bad_sample_hold", 32'(outSample), 32'h7D0);

        // CS held low across reset release; the tail of that frame must be dropped.
        inResetN = 1'b0;
        inChipSelect = 1'b0;
        sendBits(32'hFFFF, 32'hFFFF, 15, 10);
        inResetN = 1'b1;
        snap();
        sendBits(32'hFFFF, 32'hFFFF, 9, 0);
        csHigh();
        check("armed_valid", 32'(validCnt - v0), 32'd0);
        check("armed_ferr", 32'(errCnt - e0), 32'd0);
        frame(32'h3FFF, 32'h3FFF, 16);
        check("after_arm_valid", 32'(validCnt - v0), 32'd1);
        check("after_arm_sample", 32'(outSample), 32'hFFF);

        snap();
        csLow();
        check("empty_busy", 32'(outBusy), 32'h1);
        csHigh();
        check("empty_busy_drop", 32'(outBusy), 32'h0);
        check("empty_valid", 32'(validCnt - v0), 32'd0);
        check("empty_ferr", 32'(errCnt - e0), 32'd0);

        csLow();
        sendBits(32'h1234, 32'h1234, 15, 8);
        #2 inResetN = 1'b0;
        #1;
        check("midrst_sample", 32'(outSample), 32'h0);
        check("midrst_cmd", 32'(outCommand), 32'h0);
        check("midrst_busy", 32'(outBusy), 32'h0);
        cyc(2);
        inResetN = 1'b1;
        snap();
        sendBits(32'h1234, 32'h1234, 7, 0);
        csHigh();
        check("midrst_valid", 32'(validCnt - v0), 32'd0);
        check("midrst_ferr", 32'(errCnt - e0), 32'd0);

        snap();
        frame(32'h3800, 32'h3801, 16);
        check("lane_valid", 32'(validCnt - v0), 32'd1);
        check("lane_sample", 32'(outSample), 32'h800);
`ifdef LANE_CHECK_EN
        check("lane_err", 32'(outLaneError), 32'h1);
        frame(32'h3123, 32'h3123, 16);
        check("lane_err_held", 32'(outLaneError), 32'h1);
`else
        check("lane_err", 32'(outLaneError), 32'h0);
        frame(32'h3123, 32'h3123, 16);
        check("lane_err_held", 32'(outLaneError), 32'h0);
`endif
        check("lane2_sample", 32'(outSample), 32'h123);
        check("never_both", 32'(bothCnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dac_frame_receiver.md
# dac_frame_receiver

Serial-frame receiver for the 16-bit chip-select/serial-clock/data link driven by the DAC transmitter. It oversamples the link on its own system clock, assembles MSB-first frames and presents the 4-bit command nibble and 12-bit sample with a one-cycle valid strobe. Used as the in-system loopback checker for the synth audio path and as the bench-side model of the DAC chip.

## Interface
Parameters:
- FRAME_BITS, 16, serial bits per valid frame; must be 16.
- SAMPLE_BITS, 12, low bits of the frame reported as the sample.

Ports:
- inClk  input  1  system clock; must be ≥4× the serial clock frequency.
- inResetN  input  1  reset, asynchronous assert, active-low.
- inChipSelect  input  1  frame enable, active-low; asynchronous to inClk.
- inSerialClk  input  1  serial clock; data is sampled on its rising edge.
- inDataA  input  1  serial data lane A, MSB first.
- inDataB  input  1  serial data lane B; used only with LANE_CHECK_EN.
- outCommand  output  4  frame bits [15:12] of the last good frame.
- outSample  output  12  frame bits [11:0] of the last good frame.
- outValid  output  1  one-cycle pulse: outCommand/outSample updated.
- outFrameError  output  1  one-cycle pulse: frame ended with wrong bit count.
- outLaneError  output  1  sticky lane mismatch flag (LANE_CHECK_EN only, else tied 0).
- outBusy  output  1  high while in SHIFT.

## Operation
- All four serial inputs pass through two-flop synchronizers (s1, s2) plus a third history flop (s3). Reset levels: CS=1, SCLK=0, data=0.
- Edge detect on synchronized signals: SCLK rise = s2 & ~s3; CS fall = ~s2 & s3; CS rise = s2 & ~s3.
- Data is taken from the s2 stage of the data lanes, so it is aligned with the detected SCLK edge.
- FSM:
  - ARM: entered on reset. Moves to IDLE once synchronized CS is high. A frame already in progress at reset release is never captured.
  - IDLE: on CS fall, clear the shift register and the bit counter, then go to SHIFT.
  - SHIFT: on each SCLK rise, shift left with the new bit in the LSB. The bit counter increments and saturates at FRAME_BITS+1. On CS rise, evaluate the frame and return to IDLE.
- Evaluation when count == 16:
  - outCommand <= shift[15:12] and outSample <= shift[11:0].
  - outValid pulses.
- Evaluation when count is 1–15 or 17 (overflow): outFrameError pulses. Outputs hold their previous values.
- Evaluation when count == 0: frame silently ignored; no pulse.
- SCLK edges while not in SHIFT are ignored.
- Same-cycle events:
  - CS rise and SCLK rise: CS rise wins and the SCLK edge is discarded.
  - CS fall and SCLK rise: the SCLK edge is discarded and the count starts at 0.
- No command decoding; the nibble is reported raw (transmitter sends 4'b0011).

## Timing
- Reset values:
  - outCommand = 0, outSample = 0.
  - outValid = 0, outFrameError = 0, outLaneError = 0, outBusy = 0.
  - FSM state = ARM.
- Input-to-detect latency: a pin transition is captured into s1 on inClk edge 1 and s2 on edge 2. It is acted on at edge 3, so registered outputs change after the third rising inClk edge (+1 cycle metastability uncertainty).
- outValid and outFrameError are high for exactly one inClk cycle per frame, and never together.
- outBusy rises 3 edges after the CS pin falls and drops 3 edges after the CS pin rises.
- Minimum SCLK high and low time is 2 inClk periods. Minimum CS-high gap between frames is 2 inClk periods.
- Reset mid-frame clears everything immediately (asynchronously); no partial output is ever produced.

## Configuration
- LANE_CHECK_EN defined:
  - inDataB goes through its own synchronizer and is shifted alongside lane A.
  - When a frame is accepted and the A and B shift registers differ, outLaneError is set. It stays set until reset.
  - The frame is still reported from lane A.
- LANE_CHECK_EN undefined: inDataB is unused, no lane B flops are built, and outLaneError is tied 0.

## Test plan
- Reset, then a 16-bit frame 0x37D0 at SCLK = inClk/8 → outValid pulse once; outCommand = 4'h3, outSample = 12'h7D0; no error.
- Frame of 15 bits, then a frame of 17 bits → outFrameError pulses twice; no outValid; outSample keeps its previous value.
- CS held low through a reset release, then a mid-frame CS rise, then a good frame 0x3FFF → first partial frame ignored; outSample = 12'hFFF only after the full frame.
- CS low→high with no SCLK edges → no outValid, no outFrameError; outBusy pulses only.
- Reset asserted after 8 bits of a frame → all outputs 0 immediately; the remaining bits plus CS rise produce no pulse.
- LANE_CHECK_EN: frame 0x3800 on A, 0x3801 on B → outValid, outSample = 12'h800, outLaneError = 1 and held; undefined → outLaneError stays 0.
